// File: rtl/spike_isi_logger_pkg.sv
// Shared constants, event-entry type and saturating helper for the spike ISI logger.
// Build option THETA_TAG_EN adds an 8-bit threshold tag to every logged entry.
package spike_isi_logger_pkg;

    localparam int unsigned IsiWDefault = 8;
    localparam int unsigned RateW       = 8;
    localparam int unsigned ThetaW      = 8;

`ifdef THETA_TAG_EN
    localparam int unsigned TagW = ThetaW;

    typedef struct packed {
        logic [ThetaW-1:0]      theta;
        logic [IsiWDefault-1:0] isi;
    } evt_entry_t;
`else
    localparam int unsigned TagW = 0;

    typedef struct packed {
        logic [IsiWDefault-1:0] isi;
    } evt_entry_t;
`endif

    function automatic logic [RateW-1:0] sat_inc(input logic [RateW-1:0] v, input logic inc);
        return (inc && (v != {RateW{1'b1}})) ? v + RateW'(1) : v;
    endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous FIFO holding logged spike events; extra pointer bit separates full from empty.
module spike_evt_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             push_en, pop_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + (AddrW+1)'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + (AddrW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/spike_isi_logger.sv
// Spike edge detector, saturating ISI counter, event FIFO and windowed rate counter.
// Build option THETA_TAG_EN adds theta_in and tags each logged ISI with it.
module spike_isi_logger
    import spike_isi_logger_pkg::*;
#(
    parameter int unsigned ISI_W      = IsiWDefault,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WINDOW     = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  spike_in,
`ifdef THETA_TAG_EN
    input  logic [ThetaW-1:0]     theta_in,
`endif
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [ISI_W+TagW-1:0] ev_data,
    output logic                  ev_overflow,
    input  logic                  ovf_clr,
    output logic [RateW-1:0]      rate_count,
    output logic                  rate_valid
);

    localparam int unsigned     EntryW  = ISI_W + TagW;
    localparam int unsigned     WinW    = $clog2(WINDOW);
    localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);

    logic              spike_q, spike_d;
    logic [ISI_W-1:0]  isi_cnt_q, isi_cnt_d;
    logic              ovf_q, ovf_d;
    logic [WinW-1:0]   win_cnt_q, win_cnt_d;
    logic [RateW-1:0]  spk_cnt_q, spk_cnt_d;
    logic [RateW-1:0]  rate_count_q, rate_count_d;
    logic              rate_valid_q, rate_valid_d;
    logic              evt, pop, full, empty, drop;
    logic [EntryW-1:0] entry;

    assign evt      = ena & spike_in & ~spike_q;
    assign ev_valid = ~empty;
    assign pop      = ev_valid & ev_ready;
    assign drop     = evt & full & ~pop;

`ifdef THETA_TAG_EN
    assign entry = {theta_in, isi_cnt_q};
`else
    assign entry = isi_cnt_q;
`endif

    always_comb begin
        spike_d   = ena ? spike_in : spike_q;
        isi_cnt_d = isi_cnt_q;
        if (evt) begin
            isi_cnt_d = ISI_W'(1);
        end else if (ena && (isi_cnt_q != {ISI_W{1'b1}})) begin
            isi_cnt_d = isi_cnt_q + ISI_W'(1);
        end
        // Setting wins over a same-cycle clear so a drop is never missed.
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_comb begin
        win_cnt_d    = win_cnt_q;
        spk_cnt_d    = spk_cnt_q;
        rate_count_d = rate_count_q;
        rate_valid_d = 1'b0;
        if (ena) begin
            if (win_cnt_q == WinLast) begin
                rate_count_d = sat_inc(spk_cnt_q, evt);
                rate_valid_d = 1'b1;
                win_cnt_d    = '0;
                spk_cnt_d    = '0;
            end else begin
                win_cnt_d = win_cnt_q + WinW'(1);
                spk_cnt_d = sat_inc(spk_cnt_q, evt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q      <= 1'b0;
            isi_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            win_cnt_q    <= '0;
            spk_cnt_q    <= '0;
            rate_count_q <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            spike_q      <= spike_d;
            isi_cnt_q    <= isi_cnt_d;
            ovf_q        <= ovf_d;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            rate_count_q <= rate_count_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    spike_evt_fifo #(
        .Width (EntryW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (evt),
        .pop_i   (pop),
        .data_i  (entry),
        .data_o  (ev_data),
        .full_o  (full),
        .empty_o (empty)
    );

    assign ev_overflow = ovf_q;
    assign rate_count  = rate_count_q;
    assign rate_valid  = rate_valid_q;

endmodule

// File: tb/tb_spike_isi_logger.sv
// Scoreboard bench for spike_isi_logger: expected ISIs are queued at stimulus time and
// compared by a monitor on every accepted handshake.
module tb_spike_isi_logger;
    import spike_isi_logger_pkg::*;

    localparam int unsigned IsiW  = 8;
    localparam int unsigned DataW = IsiW + TagW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             spike_in = 1'b0;
    logic             ev_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             ev_valid, ev_overflow, rate_valid;
    logic [DataW-1:0] ev_data;
    logic [7:0]       rate_count;
`ifdef THETA_TAG_EN
    logic [7:0]       theta_in = 8'hA5;
`endif

    int               checks = 0;
    int               failures = 0;
    int               tick_n = -1;
    int               rv_cnt = 0;
    int               last_rv_tick = -1;
    logic [DataW-1:0] exp_q[$];

    always #5 clk = ~clk;

    spike_isi_logger #(
        .ISI_W      (IsiW),
        .FIFO_DEPTH (4),
        .WINDOW     (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .spike_in    (spike_in),
`ifdef THETA_TAG_EN
        .theta_in    (theta_in),
`endif
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_data     (ev_data),
        .ev_overflow (ev_overflow),
        .ovf_clr     (ovf_clr),
        .rate_count  (rate_count),
        .rate_valid  (rate_valid)
    );

    function automatic logic [DataW-1:0] mk(input int isi);
`ifdef THETA_TAG_EN
        return {8'hA5, IsiW'(isi)};
`else
        return IsiW'(isi);
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got %0d expected none", ev_data);
            end else begin
                check("ev_data", int'(ev_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input logic s);
        spike_in = s;
        @(posedge clk);
        #1;
        tick_n++;
        if (rate_valid) begin
            rv_cnt++;
            last_rv_tick = tick_n;
        end
    endtask

    task automatic spike_at(input int c);
        while (tick_n + 1 < c) tick(1'b0);
        tick(1'b1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ena      = 1'b1;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        exp_q.delete();
        tick(1'b0);
        rst    = 1'b0;
        tick_n = -1;
        rv_cnt = 0;
    endtask

    task automatic drain(input string name);
        ev_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick(1'b0);
        end
        tick(1'b0);
        check(name, exp_q.size(), 0);
        check({name, "_empty"}, int'(ev_valid), 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_ev_valid", int'(ev_valid), 0);
        check("rst_ev_data", int'(ev_data), 0);
        check("rst_ev_overflow", int'(ev_overflow), 0);
        check("rst_rate_count", int'(rate_count), 0);
        check("rst_rate_valid", int'(rate_valid), 0);

        // Spikes at 10, 30, 75 log 10, 20, 45; valid one cycle after each spike
        ev_ready = 1'b1;
        exp_q.push_back(mk(10)); spike_at(10); check("t1_valid_a", int'(ev_valid), 1);
        exp_q.push_back(mk(20)); spike_at(30); check("t1_valid_b", int'(ev_valid), 1);
        exp_q.push_back(mk(45)); spike_at(75); check("t1_valid_c", int'(ev_valid), 1);
        drain("t1_drain");
        check("t1_overflow", int'(ev_overflow), 0);

        // Held spike yields one event; next edge 20 cycles later logs 20
        do_reset();
        ev_ready = 1'b1;
        exp_q.push_back(mk(5));
        spike_at(5);
        for (int i = 0; i < 4; i++) tick(1'b1);
        exp_q.push_back(mk(20));
        spike_at(25);
        drain("t2_drain");

        // Overflow: 6 spikes with ready low keep the first 4
        do_reset();
        exp_q.push_back(mk(3)); exp_q.push_back(mk(2));
        exp_q.push_back(mk(4)); exp_q.push_back(mk(7));
        spike_at(3); spike_at(5); spike_at(9); spike_at(16);
        check("t3_ovf_before", int'(ev_overflow), 0);
        spike_at(20);
        check("t3_ovf_set", int'(ev_overflow), 1);
        spike_at(30);
        check("t3_head_stable", int'(ev_data), int'(mk(3)));
        drain("t3_drain");
        check("t3_ovf_sticky", int'(ev_overflow), 1);
        ovf_clr = 1'b1;
        tick(1'b0);
        ovf_clr = 1'b0;
        check("t3_ovf_clr", int'(ev_overflow), 0);

        // Full FIFO with simultaneous spike and pop: no drop
        do_reset();
        exp_q.push_back(mk(2)); exp_q.push_back(mk(2)); exp_q.push_back(mk(3));
        exp_q.push_back(mk(4)); exp_q.push_back(mk(5));
        spike_at(2); spike_at(4); spike_at(7); spike_at(11);
        while (tick_n + 1 < 16) tick(1'b0);
        ev_ready = 1'b1;
        tick(1'b1);
        check("t3b_no_drop", int'(ev_overflow), 0);
        drain("t3b_drain");
        check("t3b_ovf_final", int'(ev_overflow), 0);

        // ISI saturation
        do_reset();
        ev_ready = 1'b1;
        exp_q.push_back(mk(255));
        spike_at(300);
        drain("t4_drain");

        // Rate window of 256 with 7 spikes, last in the final window cycle
        do_reset();
        ev_ready = 1'b1;
        exp_q.push_back(mk(10)); spike_at(10);
        exp_q.push_back(mk(40)); spike_at(50);
        exp_q.push_back(mk(50)); spike_at(100);
        exp_q.push_back(mk(50)); spike_at(150);
        exp_q.push_back(mk(50)); spike_at(200);
        exp_q.push_back(mk(50)); spike_at(250);
        exp_q.push_back(mk(5));  spike_at(255);
        check("t5_rv_cnt_a", rv_cnt, 1);
        check("t5_rv_tick_a", last_rv_tick, 255);
        check("t5_rate_a", int'(rate_count), 7);
        // Second window: 50 disabled cycles delay the pulse and freeze the ISI counter
        exp_q.push_back(mk(5)); spike_at(260);
        while (tick_n + 1 < 300) tick(1'b0);
        ena = 1'b0;
        for (int i = 0; i < 50; i++) tick(i == 20);
        ena = 1'b1;
        exp_q.push_back(mk(90)); spike_at(400);
        while (tick_n + 1 < 566) tick(1'b0);
        check("t5_rv_cnt_b", rv_cnt, 2);
        check("t5_rv_tick_b", last_rv_tick, 561);
        check("t5_rate_b", int'(rate_count), 2);
        check("t5_queue", exp_q.size(), 0);

        // Reset mid-window with three queued entries
        ev_ready = 1'b0;
        spike_at(570); spike_at(575); spike_at(580);
        check("t6_pre_valid", int'(ev_valid), 1);
        check("t6_pre_rate", int'(rate_count), 2);
        do_reset();
        check("t6_valid", int'(ev_valid), 0);
        check("t6_data", int'(ev_data), 0);
        check("t6_rate", int'(rate_count), 0);
        ev_ready = 1'b1;
        exp_q.push_back(mk(7));
        spike_at(7);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_isi_logger.md
Name: spike_isi_logger

Overview:
Downstream consumer of the adaptive LIF neuron's one-bit spike output. It detects spike events, measures the inter-spike interval (ISI) in enabled clock cycles, and buffers ISI values in a small FIFO drained over a valid/ready handshake. It also reports a windowed spike-rate count, so neuron adaptation can be observed off-chip without cycle-accurate probing.

Parameters:
ISI_W, 8, width of the ISI counter and of each logged ISI value; saturating.
FIFO_DEPTH, 4, number of event entries; power of two, minimum 2.
WINDOW, 256, rate-measurement window length in enabled cycles; minimum 2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
ena  input  1  enable; when low, ISI, window and edge-detect state hold
spike_in  input  1  spike flag from the neuron stage
ev_valid  output  1  FIFO non-empty; ev_data holds the head entry
ev_ready  input  1  consumer accepts the head entry
ev_data  output  ISI_W  logged ISI value at the FIFO head
ev_overflow  output  1  sticky flag: an event was dropped because the FIFO was full
ovf_clr  input  1  clears ev_overflow
rate_count  output  8  spikes counted in the last completed window; saturates at 255
rate_valid  output  1  one-cycle pulse when rate_count updates

Behaviour:
- Reset (clk edge with rst=1): spike_q=0, isi_cnt=0, FIFO empty, ev_valid=0, ev_data=0, ev_overflow=0, win_cnt=0, spk_cnt=0, rate_count=0, rate_valid=0. Reset wins over every other input, including a reset asserted mid-window or with the FIFO non-empty; all contents are discarded.
- Edge detect: event = ena & spike_in & ~spike_q. spike_q <= spike_in only when ena=1. A spike_in held high for N cycles produces one event.
- ISI counter:
  - On an event cycle: isi_cnt <= 1.
  - Otherwise, when ena=1: isi_cnt <= isi_cnt+1, saturating at 2^ISI_W-1.
  - The value pushed on an event is the current isi_cnt before the update. Edges at enabled cycles t1 and t2 therefore log t2-t1.
  - The first event after reset logs the number of enabled cycles since reset.
- FIFO:
  - Push on event.
  - Pop when ev_valid & ev_ready. The handshake is independent of ena.
  - Latency: an event at cycle t into an empty FIFO gives ev_valid=1 with that data at t+1.
  - ev_data stays stable while ev_valid & ~ev_ready.
  - Event while full with no pop in the same cycle: the event is dropped and ev_overflow <= 1.
  - Event while full with a pop in the same cycle: push accepted, no drop.
  - Pop and push on an empty FIFO: only the push occurs (no fall-through).
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- ev_overflow:
  - Set has priority over ovf_clr in the same cycle.
  - Otherwise ovf_clr=1 clears it on the next edge.
- Rate window:
  - When ena=1, win_cnt increments each cycle and spk_cnt += event, saturating at 255.
  - When win_cnt==WINDOW-1 and ena=1: rate_count <= spk_cnt + event (saturating), rate_valid <= 1, win_cnt <= 0, spk_cnt <= 0.
  - Otherwise rate_valid <= 0. An event in the final window cycle counts toward the closing window.
- ena=0 does not clear any state and does not affect the FIFO outputs.

Optional Feature:
THETA_TAG_EN:
- Defined:
  - Adds input theta_in [7:0], the neuron's current threshold (upper bits).
  - Each FIFO entry stores {theta_in sampled on the event cycle, ISI}.
  - ev_data widens to ISI_W+8, with theta in the upper 8 bits.
- Undefined: theta_in is absent, ev_data is ISI_W wide, and storage is ISI-only.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package: ISI width default, the rate-count width constant (8), and an event-entry typedef (ISI, plus a theta tag field under THETA_TAG_EN).
- One natural sub-module: spike_evt_fifo, a synchronous FIFO parameterised on width/depth with push, pop, full, empty and head data.
- Edge detect, ISI counter and window logic stay in the top module.

Test Plan:
- Reset, then ena=1 and single-cycle spikes at enabled cycles 10, 30, 75 with ev_ready=1 -> ev_data sequence 10, 20, 45; each ev_valid rises one cycle after its spike; ev_overflow=0.
- spike_in held high for 5 cycles -> exactly one FIFO entry; the next isolated spike 20 cycles after the first edge logs 20.
- ev_ready=0 and 6 spikes -> 4 entries retained, ev_overflow=1 after the 5th spike; then ev_ready=1 -> the first 4 ISIs drain in order; ovf_clr pulse -> ev_overflow=0. Also a full FIFO with a simultaneous spike and pop -> no drop, ev_overflow remains 0.
- No spike for 300 cycles, then a spike -> logged ISI is 255 (saturated, ISI_W=8).
- WINDOW=256, 7 spikes including one in cycle 255 of the window -> rate_valid pulses once at the window end with rate_count=7; next window starts at 0. Toggle ena low for 50 cycles mid-window -> the rate_valid pulse is delayed by exactly 50 cycles.
- Assert rst with 3 queued entries, mid-window -> next cycle ev_valid=0, rate_count=0, and the first post-reset ISI counts from reset.
